// File: rtl/alu_iter.sv
// Iterative execute-stage ALU. Single-cycle ops register their result in one
// clock; shifts move the working value one bit per clock. Valid/ready on both
// sides lets the core stall while a shift is in flight.
module alu_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alucontrol,
    input  logic [XLEN-1:0] srca,
    input  logic [XLEN-1:0] srcb,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    // ALUOP_* codes shared with aludec
    localparam logic [3:0] ALUOP_ADD  = 4'b0000;
    localparam logic [3:0] ALUOP_SLL  = 4'b0001;
    localparam logic [3:0] ALUOP_SLT  = 4'b0010;
    localparam logic [3:0] ALUOP_SLTU = 4'b0011;
    localparam logic [3:0] ALUOP_XOR  = 4'b0100;
    localparam logic [3:0] ALUOP_SRL  = 4'b0101;
    localparam logic [3:0] ALUOP_OR   = 4'b0110;
    localparam logic [3:0] ALUOP_AND  = 4'b0111;
    localparam logic [3:0] ALUOP_SUB  = 4'b1000;
    localparam logic [3:0] ALUOP_SRA  = 4'b1101;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA} shift_op_t;

    state_t          state;
    shift_op_t       sh_op;
    shift_op_t       sh_sel;
    logic [4:0]      count;
    logic [XLEN-1:0] result_q;
    logic            illegal_q;

    logic [XLEN-1:0] alu_val;
    logic [XLEN-1:0] shifted;
    logic            is_shift;
    logic            is_legal;
    logic            accept;

    assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == DONE);
    assign result    = result_q;
    assign illegal   = illegal_q;
    assign zero      = (result_q == '0);

    // Decode alucontrol and evaluate the single-cycle operations
    always_comb begin
        alu_val  = '0;
        is_shift = 1'b0;
        is_legal = 1'b1;
        sh_sel   = SH_SLL;
        case (alucontrol)
            ALUOP_ADD:  alu_val = srca + srcb;
            ALUOP_SUB:  alu_val = srca - srcb;
            ALUOP_AND:  alu_val = srca & srcb;
            ALUOP_OR:   alu_val = srca | srcb;
            ALUOP_XOR:  alu_val = srca ^ srcb;
            ALUOP_SLT:  alu_val = {{(XLEN-1){1'b0}}, ($signed(srca) < $signed(srcb))};
            ALUOP_SLTU: alu_val = {{(XLEN-1){1'b0}}, (srca < srcb)};
            ALUOP_SLL: begin
                is_shift = 1'b1;
                sh_sel   = SH_SLL;
            end
            ALUOP_SRL: begin
                is_shift = 1'b1;
                sh_sel   = SH_SRL;
            end
            ALUOP_SRA: begin
                is_shift = 1'b1;
                sh_sel   = SH_SRA;
            end
            default:    is_legal = 1'b0;
        endcase
    end

    // One-bit step of the latched shift applied to the working register
    always_comb begin
        shifted = result_q;
        case (sh_op)
            SH_SLL:  shifted = {result_q[XLEN-2:0], 1'b0};
            SH_SRL:  shifted = {1'b0, result_q[XLEN-1:1]};
            SH_SRA:  shifted = {result_q[XLEN-1], result_q[XLEN-1:1]};
            default: shifted = result_q;
        endcase
    end

    // Control FSM; the result register doubles as the shift working register
    // since its contents are not visible until DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sh_op     <= SH_SLL;
            count     <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else if (accept) begin
            if (!is_legal) begin
                result_q  <= '0;
                illegal_q <= 1'b1;
                state     <= DONE;
            end else if (is_shift) begin
                result_q  <= srca;
                count     <= srcb[4:0];
                sh_op     <= sh_sel;
                illegal_q <= 1'b0;
                state     <= (srcb[4:0] == 5'd0) ? DONE : SHIFT;
            end else begin
                result_q  <= alu_val;
                illegal_q <= 1'b0;
                state     <= DONE;
            end
        end else begin
            case (state)
                SHIFT: begin
                    result_q <= shifted;
                    count    <= count - 5'd1;
                    if (count == 5'd1)
                        state <= DONE;
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= state;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
// Bench for alu_iter: directed vector table, hand-written streaming,
// backpressure and reset sequences, then random ops against a reference model.
module tb_alu_iter;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1101;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alucontrol;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;

    alu_iter #(.XLEN(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alucontrol (alucontrol),
        .srca       (srca),
        .srcb       (srcb),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ill;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic bit is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    // Reference behaviour: {illegal, result}
    function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned sh;
        sh = int'(b % 32);
        case (op)
            OP_ADD:  return {1'b0, a + b};
            OP_SUB:  return {1'b0, a - b};
            OP_AND:  return {1'b0, a & b};
            OP_OR:   return {1'b0, a | b};
            OP_XOR:  return {1'b0, a ^ b};
            OP_SLT:  return {1'b0, (($signed(a) < $signed(b)) ? 32'd1 : 32'd0)};
            OP_SLTU: return {1'b0, ((a < b) ? 32'd1 : 32'd0)};
            OP_SLL:  return {1'b0, a << sh};
            OP_SRL:  return {1'b0, a >> sh};
            OP_SRA:  return {1'b0, 32'($signed(a) >>> sh)};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    // Issue one op from IDLE, wait for completion with a bounded loop, check
    // latency and outputs, then retire it with a one-cycle out_ready pulse.
    task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input logic exp_ill);
        int lat;
        int exp_lat;
        bit ir_low;
        exp_lat = is_shift_op(op) ? int'(b % 32) + 1 : 1;
        @(negedge clk);
        check({name, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid   = 1'b1;
        alucontrol = op;
        srca       = a;
        srcb       = b;
        out_ready  = 1'b0;
        @(negedge clk);
        in_valid   = 1'b0;
        alucontrol = 4'($urandom);
        srca       = $urandom;
        srcb       = $urandom;
        lat        = 1;
        ir_low     = 1'b1;
        while (!out_valid && lat < 40) begin
            if (in_ready) ir_low = 1'b0;
            @(negedge clk);
            lat++;
        end
        check({name, ".latency"}, lat, exp_lat);
        check({name, ".busy_in_ready"}, {31'd0, ir_low}, 32'd1);
        check({name, ".result"}, result, exp_res);
        check({name, ".zero"}, {31'd0, zero}, {31'd0, exp_res == 32'd0});
        check({name, ".illegal"}, {31'd0, illegal}, {31'd0, exp_ill});
        check({name, ".done_in_ready"}, {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, ".out_valid_drop"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [32:0] r;
        logic [3:0]  undef_ops [6];
        undef_ops = '{4'd9, 4'd10, 4'd11, 4'd12, 4'd14, 4'd15};

        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        alucontrol = '0;
        srca       = '0;
        srcb       = '0;

        tbl.push_back('{OP_ADD,  32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0});
        tbl.push_back('{OP_ADD,  32'hFFFFFFFF, 32'h1,        32'h00000000, 1'b0});
        tbl.push_back('{OP_SLT,  32'hFFFFFFFF, 32'h1,        32'h00000001, 1'b0});
        tbl.push_back('{OP_SLTU, 32'hFFFFFFFF, 32'h1,        32'h00000000, 1'b0});
        tbl.push_back('{OP_SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0});
        tbl.push_back('{OP_SUB,  32'h5,        32'h5,        32'h00000000, 1'b0});
        tbl.push_back('{OP_SUB,  32'h0,        32'h1,        32'hFFFFFFFF, 1'b0});
        tbl.push_back('{OP_SRA,  32'h80000000, 32'd31,       32'hFFFFFFFF, 1'b0});
        tbl.push_back('{OP_SRL,  32'h80000000, 32'd31,       32'h00000001, 1'b0});
        tbl.push_back('{OP_SLL,  32'h1,        32'd0,        32'h00000001, 1'b0});
        tbl.push_back('{OP_SLL,  32'h1,        32'h25,       32'h00000020, 1'b0});
        tbl.push_back('{OP_OR,   32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF, 1'b0});
        tbl.push_back('{OP_XOR,  32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0});
        tbl.push_back('{4'd9,    32'h1,        32'h2,        32'h00000000, 1'b1});
        tbl.push_back('{OP_ADD,  32'h2,        32'h3,        32'h00000005, 1'b0});
        tbl.push_back('{4'd15,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1});
        tbl.push_back('{OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0});

        repeat (2) @(negedge clk);
        check("rst.in_ready",  {31'd0, in_ready},  32'd1);
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst.result",    result,             32'd0);
        check("rst.zero",      {31'd0, zero},      32'd1);
        check("rst.illegal",   {31'd0, illegal},   32'd0);
        reset = 1'b0;

        foreach (tbl[i])
            do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].ill);

        // Back-to-back streaming with out_ready held high
        @(negedge clk);
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        alucontrol = OP_ADD; srca = 32'd10; srcb = 32'd20;
        @(negedge clk);
        check("stream.v0", {31'd0, out_valid}, 32'd1);
        check("stream.r0", result, 32'd30);
        check("stream.ir0", {31'd0, in_ready}, 32'd1);
        alucontrol = OP_XOR; srca = 32'hFF00FF00; srcb = 32'h0FF00FF0;
        @(negedge clk);
        check("stream.v1", {31'd0, out_valid}, 32'd1);
        check("stream.r1", result, 32'hF0F0F0F0);
        alucontrol = OP_AND; srca = 32'h12345678; srcb = 32'h0000FFFF;
        @(negedge clk);
        check("stream.v2", {31'd0, out_valid}, 32'd1);
        check("stream.r2", result, 32'h00005678);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        srca = $urandom; srcb = $urandom;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("hold%0d.result", c), result, 32'h00005678);
            check($sformatf("hold%0d.in_ready", c), {31'd0, in_ready}, 32'd0);
            check($sformatf("hold%0d.out_valid", c), {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("hold.release", {31'd0, out_valid}, 32'd0);

        // Illegal op then legal op clears the flag, back-to-back from DONE
        @(negedge clk);
        in_valid = 1'b1; alucontrol = 4'd12; srca = 32'h5; srcb = 32'h6;
        out_ready = 1'b1;
        @(negedge clk);
        check("ill.flag", {31'd0, illegal}, 32'd1);
        check("ill.result", result, 32'd0);
        alucontrol = OP_ADD; srca = 32'd7; srcb = 32'd8;
        @(negedge clk);
        in_valid = 1'b0;
        check("ill.cleared", {31'd0, illegal}, 32'd0);
        check("ill.next", result, 32'd15);
        @(negedge clk);
        out_ready = 1'b0;
        check("ill.idle", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of a long shift
        @(negedge clk);
        in_valid = 1'b1; alucontrol = OP_SLL; srca = 32'h1; srcb = 32'd20;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("mid.busy", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        #1;
        check("mid.out_valid", {31'd0, out_valid}, 32'd0);
        check("mid.in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (out_valid) check("mid.no_pulse", {31'd0, out_valid}, 32'd0);
        end
        check("mid.idle", {31'd0, in_ready}, 32'd1);
        do_op("post_rst_add", OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0);

        // Random ops against the reference model
        for (int n = 0; n < 150; n++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            if ($urandom_range(0, 9) == 0) op = undef_ops[$urandom_range(0, 5)];
            else begin
                case ($urandom_range(0, 9))
                    0: op = OP_ADD;  1: op = OP_SUB;  2: op = OP_AND;
                    3: op = OP_OR;   4: op = OP_XOR;  5: op = OP_SLT;
                    6: op = OP_SLTU; 7: op = OP_SLL;  8: op = OP_SRL;
                    default: op = OP_SRA;
                endcase
            end
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            r = ref_alu(op, a, b);
            do_op($sformatf("rand%0d", n), op, a, b, r[31:0], r[32]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
